// File: rtl/uart_tx_frame_if.sv
// UART transmit framer port bundle: parallel word, framing options and serial line.
// The framer itself (uart_tx_frame) uses the slave modport; the upstream driver uses master.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESC_W-1:0]    Prescale;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Parity encoding matches the receive path (PAR_TYP 0 = even, 1 = odd).
// Build option: define UART_TX_STOP2_EN for two stop bits (STOP held 2*Prescale cycles).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line high, not busy, waiting for Data_Valid
// S_START  | start bit (low) for Prescale cycles
// S_DATA   | data bit idx_q for Prescale cycles, LSB first
// S_PARITY | parity of the latched word for Prescale cycles
// S_STOP   | stop bit(s) high, then back to idle
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_frame_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    // One extra bit so the two-stop-bit reload (2*Prescale-1) fits.
    localparam int CNT_W = PRESC_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  tc;
    logic [CNT_W-1:0]      bit_load;
    logic [CNT_W-1:0]      stop_load;

    // Down-counter reaches zero on the last cycle of the current bit.
    assign tc       = (cnt_q == '0);
    assign bit_load = {1'b0, presc_q} - CNT_ONE;
`ifdef UART_TX_STOP2_EN
    assign stop_load = {presc_q, 1'b0} - CNT_ONE;
`else
    assign stop_load = {1'b0, presc_q} - CNT_ONE;
`endif

    // State, latched frame configuration and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state sequencing, plus the line value for the state being entered so outputs stay registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        presc_d   = presc_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    presc_d   = (bus.Prescale == '0) ? PRESC_W'(1) : bus.Prescale;
                    cnt_d     = {1'b0, presc_d} - CNT_ONE;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tc) begin
                    idx_d   = '0;
                    cnt_d   = bit_load;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (tc) begin
                    if (idx_q == IDX_LAST) begin
                        cnt_d   = par_en_q ? bit_load : stop_load;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = bit_load;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PARITY: begin
                if (tc) begin
                    cnt_d   = stop_load;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (tc) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[idx_d];
            S_PARITY: tx_d = par_typ_d ? ~^data_d : ^data_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule
